// File: rtl/uart_frame_pkg.sv
// -----------------------------------------------------------------------------
// uart_frame_pkg
// Shared types and constants for the UART frame buffer.
//   frame_state_e  : receive FSM states (IDLE, RECV, DONE, ERROR)
//   START_CODE_DEF : default control byte that opens/restarts a frame
//   END_CODE_DEF   : default control byte that closes a frame
//   CHK_W_DEF      : default checksum width (one byte, mod-256 sum)
// -----------------------------------------------------------------------------
package uart_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } frame_state_e;

  localparam logic [7:0] START_CODE_DEF = 8'h02;
  localparam logic [7:0] END_CODE_DEF   = 8'h04;

  // The checksum is the sum of the payload bytes modulo 2**DATA_W, so it is
  // always one payload word wide; this is its width for the default byte bus.
  localparam int unsigned CHK_W_DEF = 32'd8;

endpackage : uart_frame_pkg

// File: rtl/frame_ram.sv
// -----------------------------------------------------------------------------
// frame_ram
// Simple dual-port RAM: one synchronous write port, one registered read port.
// No reset on the array or the read register so it maps onto block RAM.
// A read of the address being written in the same cycle returns the old word.
// Ports:
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address (data appears one cycle later)
//   rdata  : registered read data
// -----------------------------------------------------------------------------
module frame_ram #(
  parameter int unsigned DATA_W = 32'd8,
  parameter int unsigned ADDR_W = 32'd12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port: store the word when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port: registered read; sampling before the write gives old data on a collision.
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule : frame_ram

// File: rtl/uart_frame_buffer.sv
// -----------------------------------------------------------------------------
// uart_frame_buffer
// Frames a UART byte stream between START_CODE and END_CODE into an internal
// buffer and exposes the completed frame through a registered read port.
// Control codes are never stored. Detects overflow, reports frame length and
// waits for an explicit host release (frame_ack). START always (re)opens a
// frame, from any state, and wins over a simultaneous frame_ack.
//
// Optional feature (macro UART_FRAME_CHECKSUM_EN): the last payload byte of a
// frame is a checksum equal to the mod-2**DATA_W sum of the payload bytes
// before it. A mismatch (or an empty frame) ends in ERROR with chk_err set.
// Without the macro chk_err is tied to 0 and every payload byte is counted.
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   rx_valid   : one-cycle strobe, rx_data holds a received byte
//   rx_data    : received byte
//   frame_ack  : one-cycle host pulse releasing a completed/errored frame
//   rd_addr    : host read address
//   rd_data    : buffer word at rd_addr, one cycle later; 0 past frame_len
//                while a completed frame is held
//   frame_done : completed frame available
//   frame_len  : stored payload count of the current or last frame
//   busy       : frame reception in progress
//   overflow   : sticky, frame exceeded the buffer depth
//   chk_err    : sticky, checksum mismatch
// -----------------------------------------------------------------------------
module uart_frame_buffer
  import uart_frame_pkg::*;
#(
  parameter int unsigned DATA_W     = 32'd8,
  parameter int unsigned ADDR_W     = 32'd12,
  parameter logic [7:0]  START_CODE = START_CODE_DEF,
  parameter logic [7:0]  END_CODE   = END_CODE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              frame_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_done,
  output logic [ADDR_W:0]   frame_len,
  output logic              busy,
  output logic              overflow,
  output logic              chk_err
);

  // Control codes compared on the full word, zero-extended from 8 bits.
  localparam logic [DATA_W-1:0] START_W  = DATA_W'(START_CODE);
  localparam logic [DATA_W-1:0] END_W    = DATA_W'(END_CODE);
  // Count value meaning "buffer full": exactly 2**ADDR_W stored bytes.
  localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  frame_state_e      state_q,      state_d;
  logic [ADDR_W:0]   wr_ptr_q,     wr_ptr_d;
  logic [ADDR_W:0]   frame_len_q,  frame_len_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q,       busy_d;
  logic              overflow_q,   overflow_d;
  logic              rd_zero_q,    rd_zero_d;
`ifdef UART_FRAME_CHECKSUM_EN
  logic              chk_err_q,    chk_err_d;
  logic [DATA_W-1:0] sum_q,        sum_d;
  logic [DATA_W-1:0] prev_q,       prev_d;
`endif

  logic              is_start_s;
  logic              is_end_s;
  logic              is_pay_s;
  logic              full_s;
  logic              ram_we_s;
  logic [DATA_W-1:0] ram_rdata_s;

  assign is_start_s = rx_valid && (rx_data == START_W);
  assign is_end_s   = rx_valid && (rx_data == END_W);
  assign is_pay_s   = rx_valid && !is_start_s && !is_end_s;
  assign full_s     = (wr_ptr_q == FULL_CNT);

  frame_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (rx_data),
    .raddr (rd_addr),
    .rdata (ram_rdata_s)
  );

  // Next-state logic: FSM transitions, write pointer, length and sticky flags.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    frame_len_d = frame_len_q;
    overflow_d  = overflow_q;
    ram_we_s    = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
    chk_err_d   = chk_err_q;
    sum_d       = sum_q;
    prev_d      = prev_q;
`endif

    if (is_start_s) begin
      // START opens a fresh frame from every state; partial data is dropped.
      state_d     = ST_RECV;
      wr_ptr_d    = {(ADDR_W+1){1'b0}};
      frame_len_d = {(ADDR_W+1){1'b0}};
      overflow_d  = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      chk_err_d   = 1'b0;
      sum_d       = {DATA_W{1'b0}};
      prev_d      = {DATA_W{1'b0}};
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RECV: begin
          if (is_end_s) begin
`ifdef UART_FRAME_CHECKSUM_EN
            // prev_q is the checksum; sum_q - prev_q is the sum of the bytes before it.
            if (wr_ptr_q == {(ADDR_W+1){1'b0}}) begin
              state_d   = ST_ERROR;
              chk_err_d = 1'b1;
            end else if ((sum_q - prev_q) == prev_q) begin
              state_d     = ST_DONE;
              frame_len_d = wr_ptr_q - 1'b1;
            end else begin
              state_d   = ST_ERROR;
              chk_err_d = 1'b1;
            end
`else
            state_d = ST_DONE;
`endif
          end else if (is_pay_s) begin
            if (full_s) begin
              // Byte beyond the depth is dropped; buffer contents stay intact.
              state_d    = ST_ERROR;
              overflow_d = 1'b1;
            end else begin
              ram_we_s    = 1'b1;
              wr_ptr_d    = wr_ptr_q + 1'b1;
              frame_len_d = frame_len_q + 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
              sum_d       = sum_q + rx_data;
              prev_d      = rx_data;
`endif
            end
          end else begin
            state_d = ST_RECV;
          end
        end
        ST_DONE, ST_ERROR: begin
          // Buffer is write-protected here; only a release leaves the state.
          if (frame_ack) begin
            state_d = ST_IDLE;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d       = (state_d == ST_RECV);
    frame_done_d = (state_d == ST_DONE);
    // Reads past the end of a held frame return zero; decided with the address.
    rd_zero_d    = frame_done_q && ({1'b0, rd_addr} >= frame_len_q);
  end

  // State and registered outputs; asynchronous reset aborts any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= {(ADDR_W+1){1'b0}};
      frame_len_q  <= {(ADDR_W+1){1'b0}};
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      rd_zero_q    <= 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
      chk_err_q    <= 1'b0;
      sum_q        <= {DATA_W{1'b0}};
      prev_q       <= {DATA_W{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      frame_len_q  <= frame_len_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      rd_zero_q    <= rd_zero_d;
`ifdef UART_FRAME_CHECKSUM_EN
      chk_err_q    <= chk_err_d;
      sum_q        <= sum_d;
      prev_q       <= prev_d;
`endif
    end
  end

  // rd_zero_q resets to 1 so rd_data reads 0 out of reset without resetting the RAM.
  assign rd_data    = rd_zero_q ? {DATA_W{1'b0}} : ram_rdata_s;
  assign frame_done = frame_done_q;
  assign frame_len  = frame_len_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
`ifdef UART_FRAME_CHECKSUM_EN
  assign chk_err    = chk_err_q;
`else
  assign chk_err    = 1'b0;
`endif

endmodule : uart_frame_buffer

// File: tb/tb_uart_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_buffer
// Self-checking bench for uart_frame_buffer with a 16-entry buffer.
// Directed vector table, hand-written boundary/reset sequences and a random
// byte stream compared against a queue-based frame model.
// -----------------------------------------------------------------------------
module tb_uart_frame_buffer;

  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       frame_ack;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_done;
  logic [4:0] frame_len;
  logic       busy;
  logic       overflow;
  logic       chk_err;

  int n_checks = 0;
  int n_err    = 0;

`ifdef UART_FRAME_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  uart_frame_buffer #(
    .DATA_W (8),
    .ADDR_W (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .frame_ack  (frame_ack),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .busy       (busy),
    .overflow   (overflow),
    .chk_err    (chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input bit v, input logic [7:0] d, input bit ack, input logic [3:0] a);
    rx_valid  = v;
    rx_data   = d;
    frame_ack = ack;
    rd_addr   = a;
    @(posedge clk);
    #1;
    rx_valid  = 1'b0;
    frame_ack = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, 1'b0, 4'd0);
  endtask

  task automatic check_outs(input string tag, input bit e_done, input int e_len,
                            input bit e_busy, input bit e_ovf, input bit e_chk);
    check({tag, " frame_done"}, {31'd0, frame_done}, {31'd0, e_done});
    check({tag, " frame_len"},  {27'd0, frame_len},  e_len);
    check({tag, " busy"},       {31'd0, busy},       {31'd0, e_busy});
    check({tag, " overflow"},   {31'd0, overflow},   {31'd0, e_ovf});
    check({tag, " chk_err"},    {31'd0, chk_err},    {31'd0, e_chk});
  endtask

  // ---------------- behavioural model ----------------
  bit         m_rx, m_done, m_err, m_ovf, m_chk;
  int         m_len;
  logic [7:0] pay_q[$];
  logic [7:0] mem_m [16];
  bit         mem_ok [16];

  task automatic model_reset();
    m_rx = 1'b0; m_done = 1'b0; m_err = 1'b0; m_ovf = 1'b0; m_chk = 1'b0;
    m_len = 0;
    pay_q.delete();
    for (int k = 0; k < 16; k++) mem_ok[k] = 1'b0;
  endtask

  task automatic model_apply(input bit v, input logic [7:0] d, input bit ack);
    logic [7:0] s;
    int         n;
    if (v && d == 8'h02) begin
      m_rx = 1'b1; m_done = 1'b0; m_err = 1'b0; m_ovf = 1'b0; m_chk = 1'b0;
      pay_q.delete();
      m_len = 0;
    end else if (m_rx) begin
      if (v && d == 8'h04) begin
        m_rx = 1'b0;
        n = pay_q.size();
        if (!CHK_EN) begin
          m_done = 1'b1;
          m_len  = n;
        end else if (n == 0) begin
          m_err = 1'b1; m_chk = 1'b1;
        end else begin
          s = 8'h00;
          for (int k = 0; k < n - 1; k++) s = s + pay_q[k];
          if (s == pay_q[n-1]) begin
            m_done = 1'b1;
            m_len  = n - 1;
          end else begin
            m_err = 1'b1; m_chk = 1'b1;
          end
        end
      end else if (v) begin
        if (pay_q.size() == 16) begin
          m_rx = 1'b0; m_err = 1'b1; m_ovf = 1'b1;
        end else begin
          mem_m[pay_q.size()]  = d;
          mem_ok[pay_q.size()] = 1'b1;
          pay_q.push_back(d);
          m_len = pay_q.size();
        end
      end
    end else if (ack && (m_done || m_err)) begin
      m_done = 1'b0;
      m_err  = 1'b0;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         ack;
    logic [3:0] a;
    bit         crd;
    logic [7:0] erd;
    bit         edone;
    int         elen;
    bit         ebusy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit v, logic [7:0] d, bit ack, logic [3:0] a, bit crd,
                              logic [7:0] erd, bit edone, int elen, bit ebusy);
    vec_t r;
    r.v = v; r.d = d; r.ack = ack; r.a = a; r.crd = crd; r.erd = erd;
    r.edone = edone; r.elen = elen; r.ebusy = ebusy;
    return r;
  endfunction

  int         ps, pe, r;
  bit         rv, rack, rd_known;
  logic [7:0] rd8, exp_rd;
  logic [3:0] ra;

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; frame_ack = 1'b0; rd_addr = 4'd0;
    #12;
    check_outs("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    check("reset rd_data", {24'd0, rd_data}, 32'd0);
    rst_n = 1'b1;

`ifndef UART_FRAME_CHECKSUM_EN
    // basic frame and readback
    vt.push_back(mk(1, 8'h02, 0, 4'd0,  0, 8'h00, 0, 0, 1));
    vt.push_back(mk(1, 8'h41, 0, 4'd0,  0, 8'h00, 0, 1, 1));
    vt.push_back(mk(1, 8'h42, 0, 4'd0,  0, 8'h00, 0, 2, 1));
    vt.push_back(mk(1, 8'h43, 0, 4'd0,  0, 8'h00, 0, 3, 1));
    vt.push_back(mk(1, 8'h04, 0, 4'd0,  0, 8'h00, 1, 3, 0));
    vt.push_back(mk(0, 8'h00, 0, 4'd0,  1, 8'h41, 1, 3, 0));
    vt.push_back(mk(0, 8'h00, 0, 4'd1,  1, 8'h42, 1, 3, 0));
    vt.push_back(mk(0, 8'h00, 0, 4'd2,  1, 8'h43, 1, 3, 0));
    vt.push_back(mk(0, 8'h00, 0, 4'd3,  1, 8'h00, 1, 3, 0));
    vt.push_back(mk(0, 8'h00, 0, 4'd15, 1, 8'h00, 1, 3, 0));
    // restart mid-frame
    vt.push_back(mk(1, 8'h02, 0, 4'd0,  0, 8'h00, 0, 0, 1));
    vt.push_back(mk(1, 8'h11, 0, 4'd0,  0, 8'h00, 0, 1, 1));
    vt.push_back(mk(1, 8'h22, 0, 4'd0,  0, 8'h00, 0, 2, 1));
    vt.push_back(mk(1, 8'h02, 0, 4'd0,  0, 8'h00, 0, 0, 1));
    vt.push_back(mk(1, 8'h33, 0, 4'd0,  0, 8'h00, 0, 1, 1));
    vt.push_back(mk(1, 8'h04, 0, 4'd0,  0, 8'h00, 1, 1, 0));
    vt.push_back(mk(0, 8'h00, 0, 4'd0,  1, 8'h33, 1, 1, 0));
    vt.push_back(mk(0, 8'h00, 0, 4'd1,  1, 8'h00, 1, 1, 0));
    // release: unmasked read afterwards, IDLE ignores END and payload
    vt.push_back(mk(0, 8'h00, 1, 4'd0,  0, 8'h00, 0, 1, 0));
    vt.push_back(mk(0, 8'h00, 0, 4'd1,  1, 8'h22, 0, 1, 0));
    vt.push_back(mk(1, 8'h04, 0, 4'd0,  0, 8'h00, 0, 1, 0));
    vt.push_back(mk(1, 8'h55, 0, 4'd0,  0, 8'h00, 0, 1, 0));
    // ack + START collision, then read-during-write returns old data
    vt.push_back(mk(1, 8'h02, 0, 4'd0,  0, 8'h00, 0, 0, 1));
    vt.push_back(mk(1, 8'h66, 0, 4'd0,  0, 8'h00, 0, 1, 1));
    vt.push_back(mk(1, 8'h04, 0, 4'd0,  0, 8'h00, 1, 1, 0));
    vt.push_back(mk(1, 8'h02, 1, 4'd0,  0, 8'h00, 0, 0, 1));
    vt.push_back(mk(1, 8'h77, 0, 4'd0,  1, 8'h66, 0, 1, 1));
    vt.push_back(mk(0, 8'h00, 0, 4'd0,  1, 8'h77, 0, 1, 1));
    vt.push_back(mk(1, 8'h04, 0, 4'd0,  0, 8'h00, 1, 1, 0));

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].v, vt[i].d, vt[i].ack, vt[i].a);
      check_outs($sformatf("vec%0d", i), vt[i].edone, vt[i].elen, vt[i].ebusy, 1'b0, 1'b0);
      if (vt[i].crd) check($sformatf("vec%0d rd_data", i), {24'd0, rd_data}, {24'd0, vt[i].erd});
    end

    // exactly 16 payload bytes then END is a legal full frame
    send(8'h02);
    for (int i = 0; i < 16; i++) send(8'hA0 + 8'(i));
    check_outs("full16", 1'b0, 16, 1'b1, 1'b0, 1'b0);
    send(8'h04);
    check_outs("full16 end", 1'b1, 16, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 4'd15);
    check("full16 rd15", {24'd0, rd_data}, 32'hAF);

    // 17th payload byte overflows; stored bytes stay intact
    send(8'h02);
    for (int i = 0; i < 16; i++) send(8'hB0 + 8'(i));
    check_outs("ovf pre", 1'b0, 16, 1'b1, 1'b0, 1'b0);
    send(8'hC0);
    check_outs("ovf", 1'b0, 16, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b0, 4'(i));
      check($sformatf("ovf rd%0d", i), {24'd0, rd_data}, {24'd0, 8'hB0 + 8'(i)});
    end
    step(1'b0, 8'h00, 1'b1, 4'd0);
    check_outs("ovf ack", 1'b0, 16, 1'b0, 1'b1, 1'b0);
    send(8'h02);
    check_outs("ovf clr", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    send(8'h04);
    check_outs("empty end", 1'b1, 0, 1'b0, 1'b0, 1'b0);
`else
    send(8'h02); send(8'h05); send(8'h07); send(8'h0C); send(8'h04);
    check_outs("chk good", 1'b1, 2, 1'b0, 1'b0, 1'b0);
    send(8'h02); send(8'h05); send(8'h07); send(8'h0D); send(8'h04);
    check_outs("chk bad", 1'b0, 3, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 4'd0);
    check_outs("chk ack", 1'b0, 3, 1'b0, 1'b0, 1'b1);
    send(8'h02);
    check_outs("chk clr", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    send(8'h04);
    check_outs("chk empty", 1'b0, 0, 1'b0, 1'b0, 1'b1);
    send(8'h02); send(8'h00); send(8'h04);
    check_outs("chk zero", 1'b1, 0, 1'b0, 1'b0, 1'b0);
`endif

    // asynchronous reset between clock edges aborts the frame at once
    send(8'h02);
    send(8'h11);
    check_outs("pre rst", 1'b0, 1, 1'b1, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_outs("async rst", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    check("async rst rd_data", {24'd0, rd_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h04);
    check_outs("post rst end", 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // random stream against the model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      case (i / 500)
        0:       begin ps = 4;  pe = 8;  end
        1:       begin ps = 1;  pe = 2;  end
        default: begin ps = 10; pe = 10; end
      endcase
      rv = ($urandom_range(0, 3) != 0);
      r  = $urandom_range(0, 99);
      if (r < ps)           rd8 = 8'h02;
      else if (r < ps + pe) rd8 = 8'h04;
      else                  rd8 = 8'($urandom_range(0, 255));
      rack = ($urandom_range(0, 9) == 0);
      ra   = 4'($urandom_range(0, 15));
      rd_known = 1'b1;
      exp_rd   = 8'h00;
      if (m_done && int'(ra) >= m_len) exp_rd = 8'h00;
      else if (mem_ok[ra])             exp_rd = mem_m[ra];
      else                             rd_known = 1'b0;
      model_apply(rv, rd8, rack);
      step(rv, rd8, rack, ra);
      check_outs($sformatf("rnd%0d", i), m_done, m_len, m_rx, m_ovf, m_chk);
      if (rd_known) check($sformatf("rnd%0d rd_data", i), {24'd0, rd_data}, {24'd0, exp_rd});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_uart_frame_buffer
